trace_filter_cfg: RTL and testbench

Runtime-configurable successor to the fixed control-flow trace filter. It sits between the CPU instruction trace tap and the continuous-monitoring pipeline, and classifies each valid retired instruction against a programmable class mask. It decides keep/drop under one of four modes, including a post-trigger window mode that keeps N instructions following each matching one. Registered outputs carry the instruction, a valid flag and the drop decision, together with saturating keep/drop statistics counters.

---
 rtl/trace_filter_cfg.sv | 160 ++++++++++++++++
 tb/tb_trace_filter_cfg.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/trace_filter_cfg.sv
// Runtime-configurable control-flow trace filter: classifies retired instructions
// against a class mask and decides keep/drop under one of four modes.
module trace_filter_cfg #(
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned WINDOW_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             instr,
  input  logic                    pc_valid,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_addr,
  input  logic [31:0]             cfg_wdata,
  output logic [31:0]             instr_out,
  output logic                    valid_out,
  output logic                    drop_instr,
  output logic [CNT_WIDTH-1:0]    keep_count,
  output logic [CNT_WIDTH-1:0]    drop_count
);

  localparam int unsigned CLASS_W = 6;
  localparam int unsigned MODE_W  = 2;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [1:0] ADDR_MODE   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_WINLEN = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  localparam logic [MODE_W-1:0] MODE_PASS_ALL = 2'd0;
  localparam logic [MODE_W-1:0] MODE_DROP_ALL = 2'd1;
  localparam logic [MODE_W-1:0] MODE_FILTER   = 2'd2;
  localparam logic [MODE_W-1:0] MODE_WINDOW   = 2'd3;

  typedef enum logic {ST_IDLE, ST_WINDOW} state_t;

  logic [MODE_W-1:0]       r_mode;
  logic [CLASS_W-1:0]      r_mask;
  logic [WINDOW_WIDTH-1:0] r_win_len;
  logic [WINDOW_WIDTH-1:0] r_cnt;
  state_t                  r_state;

  logic [CLASS_W-1:0] w_class;
  logic               w_hit;
  logic               w_keep;
  logic               w_wr_mode;
  logic               w_wr_clear;
  logic               w_unused;

  // Class decode; compressed encodings (instr[1:0] != 2'b11) never match.
  always_comb begin
    w_class = '0;
    if (instr[1:0] == 2'b11) begin
      w_class[0] = (instr[6:0] == OP_JAL);
      w_class[1] = (instr[6:0] == OP_JALR) && (instr[14:12] == 3'b000);
      w_class[2] = (instr[6:0] == OP_BRANCH);
      w_class[3] = (instr[6:0] == OP_SYSTEM);
      w_class[4] = (instr[6:0] == OP_LOAD);
      w_class[5] = (instr[6:0] == OP_STORE);
    end
  end

  assign w_hit      = |(w_class & r_mask);
  assign w_wr_mode  = cfg_we && (cfg_addr == ADDR_MODE);
  assign w_wr_clear = cfg_we && (cfg_addr == ADDR_CLEAR);
  assign w_unused   = ^cfg_wdata;

  // Decision uses the FSM state before this instruction's own update.
  always_comb begin
    w_keep = 1'b0;
    case (r_mode)
      MODE_PASS_ALL: w_keep = 1'b1;
      MODE_DROP_ALL: w_keep = 1'b0;
      MODE_FILTER:   w_keep = w_hit;
      MODE_WINDOW:   w_keep = w_hit || (r_state == ST_WINDOW);
      default:       w_keep = 1'b0;
    endcase
  end

  // Configuration registers; writes apply from the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode    <= MODE_FILTER;
      r_mask    <= 6'b000111;
      r_win_len <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_MODE:   r_mode    <= cfg_wdata[MODE_W-1:0];
        ADDR_MASK:   r_mask    <= cfg_wdata[CLASS_W-1:0];
        ADDR_WINLEN: r_win_len <= cfg_wdata[WINDOW_WIDTH-1:0];
        default:     ;
      endcase
    end
  end

  // Post-trigger window FSM; a MODE write restarts it from IDLE.
  always_ff @(posedge clk) begin
    if (rst || w_wr_mode) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (pc_valid && (r_mode == MODE_WINDOW)) begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit && (r_win_len != '0)) begin
            r_state <= ST_WINDOW;
            r_cnt   <= r_win_len;
          end
        end
        ST_WINDOW: begin
          if (w_hit) begin
            r_cnt <= r_win_len;
          end else if (r_cnt == WINDOW_WIDTH'(1)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - WINDOW_WIDTH'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Registered instruction path.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_out  <= '0;
      valid_out  <= 1'b0;
      drop_instr <= 1'b1;
    end else begin
      instr_out  <= instr;
      valid_out  <= pc_valid;
      drop_instr <= !(pc_valid && w_keep);
    end
  end

  // Saturating statistics; CLEAR beats a same-cycle instruction.
  always_ff @(posedge clk) begin
    if (rst || w_wr_clear) begin
      keep_count <= '0;
      drop_count <= '0;
    end else if (pc_valid) begin
      if (w_keep) begin
        if (keep_count != '1) keep_count <= keep_count + CNT_WIDTH'(1);
      end else begin
        if (drop_count != '1) drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_trace_filter_cfg.sv
// Directed self-checking bench for trace_filter_cfg (built with 4-bit counters).
module tb_trace_filter_cfg;

  localparam int unsigned CW = 4;
  localparam int unsigned WW = 8;

  localparam logic [31:0] JAL  = 32'h0000006F;
  localparam logic [31:0] ADDI = 32'h00000013;
  localparam logic [31:0] LOAD = 32'h00002003;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          pc_valid;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [31:0]   cfg_wdata;
  logic [31:0]   instr_out;
  logic          valid_out;
  logic          drop_instr;
  logic [CW-1:0] keep_count;
  logic [CW-1:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;

  trace_filter_cfg #(.CNT_WIDTH(CW), .WINDOW_WIDTH(WW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .pc_valid(pc_valid),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .instr_out(instr_out), .valid_out(valid_out), .drop_instr(drop_instr),
    .keep_count(keep_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the edge.
  task automatic cyc(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                     input logic v, input logic [31:0] ins);
    cfg_we = we; cfg_addr = addr; cfg_wdata = wd; pc_valid = v; instr = ins;
    @(posedge clk);
    #1;
    cfg_we = 1'b0; pc_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] wd);
    cyc(1'b1, addr, wd, 1'b0, 32'h0);
  endtask

  task automatic send(input logic [31:0] ins, input logic exp_drop, input string tag);
    cyc(1'b0, 2'd0, 32'h0, 1'b1, ins);
    check(tag, 32'(drop_instr), 32'(exp_drop));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr_out"}, instr_out, 32'h0);
    check({tag, "_valid_out"}, 32'(valid_out), 32'h0);
    check({tag, "_drop"}, 32'(drop_instr), 32'h1);
    check({tag, "_keep"}, 32'(keep_count), 32'h0);
    check({tag, "_dropcnt"}, 32'(drop_count), 32'h0);
  endtask

  initial begin
    rst = 1'b1; instr = '0; pc_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Legacy defaults: JAL/JALR/BRANCH kept.
    send(32'h00000000, 1'b1, "def_zero");
    send(JAL,          1'b0, "def_jal");
    check("def_instr_out", instr_out, JAL);
    check("def_valid_out", 32'(valid_out), 32'h1);
    send(32'h0C601063, 1'b0, "def_branch");
    send(32'h00000067, 1'b0, "def_jalr");
    send(ADDI,         1'b1, "def_addi");
    check("def_keep", 32'(keep_count), 32'd3);
    check("def_dropc", 32'(drop_count), 32'd2);

    // Invalid cycle: dropped, counters untouched.
    cyc(1'b0, 2'd0, 32'h0, 1'b0, JAL);
    check("gate_valid", 32'(valid_out), 32'h0);
    check("gate_drop", 32'(drop_instr), 32'h1);
    check("gate_keep", 32'(keep_count), 32'd3);
    check("gate_dropc", 32'(drop_count), 32'd2);

    // Window mode, length 2.
    wr(2'd0, 32'd3);
    wr(2'd2, 32'd2);
    send(JAL,  1'b0, "win_jal");
    send(ADDI, 1'b0, "win_a1");
    send(ADDI, 1'b0, "win_a2");
    send(ADDI, 1'b1, "win_a3");
    send(JAL,  1'b0, "rt_jal1");
    send(ADDI, 1'b0, "rt_a1");
    send(JAL,  1'b0, "rt_jal2");
    send(ADDI, 1'b0, "rt_a2");
    send(ADDI, 1'b0, "rt_a3");
    send(ADDI, 1'b1, "rt_a4");
    check("win_keep", 32'(keep_count), 32'd11);
    check("win_dropc", 32'(drop_count), 32'd4);

    // Modes and mask.
    wr(2'd0, 32'd0);
    send(ADDI, 1'b0, "pass_addi");
    wr(2'd0, 32'd1);
    send(JAL, 1'b1, "dropall_jal");
    wr(2'd0, 32'd2);
    wr(2'd1, 32'h10);
    send(LOAD, 1'b0, "mask_load");
    send(JAL,  1'b1, "mask_jal");
    wr(2'd1, 32'h3F);
    send(32'h00000001, 1'b1, "compressed");
    check("modes_keep", 32'(keep_count), 32'd13);
    check("modes_dropc", 32'(drop_count), 32'd7);

    // Drop counter saturates at 15.
    wr(2'd0, 32'd1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 2'd0, 32'h0, 1'b1, JAL);
    check("sat_dropc", 32'(drop_count), 32'd15);
    check("sat_keep", 32'(keep_count), 32'd13);

    // CLEAR wins over a same-cycle valid instruction.
    cyc(1'b1, 2'd3, 32'hFFFF_FFFF, 1'b1, JAL);
    check("clr_keep", 32'(keep_count), 32'd0);
    check("clr_dropc", 32'(drop_count), 32'd0);
    check("clr_valid", 32'(valid_out), 32'h1);

    // Same-cycle MODE write: instruction uses the old (DROP_ALL) mode.
    cyc(1'b1, 2'd0, 32'd0, 1'b1, ADDI);
    check("oldcfg_drop", 32'(drop_instr), 32'h1);
    send(ADDI, 1'b0, "newcfg_keep");
    check("oldcfg_keep", 32'(keep_count), 32'd1);
    check("oldcfg_dropc", 32'(drop_count), 32'd1);

    // Reset in the middle of a window.
    wr(2'd0, 32'd3);
    wr(2'd2, 32'd5);
    send(JAL,  1'b0, "mid_jal");
    send(ADDI, 1'b0, "mid_addi");
    rst = 1'b1;
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    check_reset_outputs("midrst");
    send(ADDI, 1'b1, "post_rst_addi");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
